// File: rtl/leb128_reader_pkg.sv
// Shared constants, state encoding and datapath helpers for the LEB128 reader.
//   LEB_MAX_BYTES  : longest legal encoding of a 32-bit value
//   LEB_CONT_BIT   : continuation flag position inside an encoded byte
//   state_t        : reader FSM states (IDLE=0, FETCH=1, DONE=2, ERR=3)
//   leb_accumulate : merge one 7-bit group into the accumulator, sign-extend on the last byte
//   leb_fifth_ok   : unused-bit rule for the fifth byte of a 32-bit encoding
package leb128_reader_pkg;

  localparam int LEB_MAX_BYTES = 5;
  localparam int LEB_CONT_BIT  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  // payload is the low seven bits of the byte; shift is the bit position of its lsb.
  // On the terminating byte of a signed value, bit 6 of the payload is the sign and is
  // copied into every bit above the group, unless the group already reaches bit 31.
  function automatic logic [31:0] leb_accumulate(input logic [31:0] acc,
                                                 input logic [6:0]  payload,
                                                 input logic [4:0]  shift,
                                                 input logic        sgn,
                                                 input logic        last);
    logic [31:0] field;
    logic [31:0] result;
    logic [5:0]  top;
    field  = 32'(payload) << shift;
    result = acc | field;
    top    = 6'(shift) + 6'd7;
    if (last && sgn && payload[6] && (top < 6'd32)) begin
      result = result | (32'hFFFF_FFFF << top);
    end
    return result;
  endfunction

  // hi = byte[6:3]. Only bits [3:0] of the fifth byte land inside 32 bits; the bits
  // above must be zero (u32) or copies of bit 3 (s32), otherwise the value overflows.
  function automatic logic leb_fifth_ok(input logic [3:0] hi, input logic sgn);
    logic ok;
    if (sgn) ok = (hi[3:1] == {3{hi[0]}});
    else     ok = (hi[3:1] == 3'b000);
    return ok;
  endfunction

endpackage

// File: rtl/leb128_reader_if.sv
// Byte-wide ROM read port used by the LEB128 reader.
//   rom_addr     : byte address (reader -> ROM)
//   rom_read_en  : read request, held until rom_ready (reader -> ROM)
//   rom_data_out : read data, valid while rom_ready is high (ROM -> reader)
//   rom_ready    : one-cycle pulse answering a request (ROM -> reader)
// modport master is the reader side, modport slave is the ROM side.
interface leb128_reader_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_read_en;
  logic [7:0]        rom_data_out;
  logic              rom_ready;

  modport master (
    output rom_addr,
    output rom_read_en,
    input  rom_data_out,
    input  rom_ready
  );

  modport slave (
    input  rom_addr,
    input  rom_read_en,
    output rom_data_out,
    output rom_ready
  );

endinterface

// File: rtl/leb128_reader.sv
// Byte-serial LEB128 decoder (u32 / s32) sitting between the byte ROM and the
// wasm loader / immediate fetch path.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : begin a decode (only looked at while idle)
//   start_addr  : address of the first encoded byte
//   is_signed   : 1 = s32 with sign extension, 0 = u32
//   busy        : decode in progress
//   done/error  : one-cycle result pulses
//   value       : decoded value, held until the next successful decode
//   length      : bytes consumed (1..5), held
//   next_addr   : address just past the encoding, held
//   rom         : ROM read port (master side)
module leb128_reader
  import leb128_reader_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_BYTES = LEB_MAX_BYTES,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              is_signed,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       value,
  output logic [2:0]        length,
  output logic [ADDR_W-1:0] next_addr,
  leb128_reader_if.master   rom
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  state_t             state;
  state_t             next_state;
  logic [ADDR_W-1:0]  cur_addr;
  logic               sgn;
  logic [31:0]        acc;
  logic [4:0]         shift;
  logic [2:0]         count;
  logic [TIMER_W-1:0] timer;

  logic [7:0]  byte_in;
  logic [2:0]  count_inc;
  logic        last_byte;
  logic        terminates;
  logic        fifth_ok;
  logic        timer_expired;
  logic [31:0] acc_next;

  assign byte_in       = rom.rom_data_out;
  assign count_inc     = count + 3'd1;
  assign last_byte     = (count_inc == 3'(MAX_BYTES));
  assign terminates    = !byte_in[LEB_CONT_BIT];
  assign fifth_ok      = leb_fifth_ok(byte_in[6:3], sgn);
  assign timer_expired = (timer == TIMER_W'(TIMEOUT - 1));
  assign acc_next      = leb_accumulate(acc, byte_in[6:0], shift, sgn, terminates);

  // The request address is the current byte address; it simply holds outside FETCH.
  assign rom.rom_addr    = cur_addr;
  assign rom.rom_read_en = (state == FETCH);

  assign busy  = (state == FETCH);
  assign done  = (state == DONE);
  assign error = (state == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    // NOTE: next_state gets its default before the case so every path assigns it
    // and no latch is inferred.
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) next_state = FETCH;
      end
      FETCH: begin
        if (rom.rom_ready) begin
          // The fifth byte must both terminate and keep its unused bits clean.
          if (last_byte && (!terminates || !fifth_ok)) next_state = ERR;
          else if (terminates)                         next_state = DONE;
        end else if (timer_expired) begin
          next_state = ERR;
        end
      end
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr  <= '0;
      sgn       <= 1'b0;
      acc       <= '0;
      shift     <= '0;
      count     <= '0;
      timer     <= '0;
      value     <= '0;
      length    <= '0;
      next_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cur_addr <= start_addr;
            sgn      <= is_signed;
            acc      <= '0;
            shift    <= '0;
            count    <= '0;
            timer    <= '0;
          end
        end
        FETCH: begin
          if (rom.rom_ready) begin
            acc   <= acc_next;
            count <= count_inc;
            timer <= '0;
            if (next_state == FETCH) begin
              // Moving the address is also what makes the ROM answer the next byte.
              cur_addr <= cur_addr + ADDR_W'(1);
              shift    <= shift + 5'd7;
            end
            if (next_state == DONE) begin
              value     <= acc_next;
              length    <= count_inc;
              next_addr <= cur_addr + ADDR_W'(1);
            end
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_leb128_reader.sv
// Self-checking bench for leb128_reader: registered byte ROM model, expected results
// queued when a decode is launched and compared when done/error appears.
module tb_leb128_reader;
  import leb128_reader_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              is_signed;
  logic              busy;
  logic              done;
  logic              error;
  logic [31:0]       value;
  logic [2:0]        length;
  logic [ADDR_W-1:0] next_addr;

  leb128_reader_if #(.ADDR_W(ADDR_W)) rom_bus ();

  leb128_reader #(.ADDR_W(ADDR_W), .MAX_BYTES(5), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .value     (value),
    .length    (length),
    .next_addr (next_addr),
    .rom       (rom_bus)
  );

  always #5 clk = ~clk;

  // Registered ROM: answers a pending request one cycle later, then drops ready so the
  // reader has to move the address before the next byte arrives.
  logic [7:0] mem [0:255];
  bit rom_enable = 1'b1;
  bit stray_req  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      rom_bus.rom_ready <= 1'b0;
    end else if (rom_bus.rom_ready) begin
      rom_bus.rom_ready <= 1'b0;
    end else if ((rom_bus.rom_read_en && rom_enable) || stray_req) begin
      rom_bus.rom_ready    <= 1'b1;
      rom_bus.rom_data_out <= mem[rom_bus.rom_addr[7:0]];
    end
  end

  typedef struct {
    bit          is_err;
    logic [31:0] value;
    logic [2:0]  length;
    logic [31:0] next_addr;
    logic [31:0] rom_last;
    int          edges;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          sgn;
    bit          is_err;
    logic [31:0] value;
    int          nbytes;
  } vec_t;

  exp_t sb[$];
  int tests_run    = 0;
  int tests_failed = 0;

  // Values the outputs should be holding (only a successful decode or reset changes them).
  logic [31:0] held_value = '0;
  logic [2:0]  held_len   = '0;
  logic [31:0] held_next  = '0;

  // Two cycles per byte (address cycle, ready cycle); edges count from the start-accepting edge.
  task automatic push_done(input logic [31:0] a, input logic [31:0] v, input int n);
    exp_t e;
    e.is_err    = 1'b0;
    e.value     = v;
    e.length    = 3'(n);
    e.next_addr = a + 32'(n);
    e.rom_last  = a + 32'(n - 1);
    e.edges     = 2 * n;
    held_value  = e.value;
    held_len    = e.length;
    held_next   = e.next_addr;
    sb.push_back(e);
  endtask

  task automatic push_err(input logic [31:0] rom_last, input int edges);
    exp_t e;
    e.is_err    = 1'b1;
    e.value     = held_value;
    e.length    = held_len;
    e.next_addr = held_next;
    e.rom_last  = rom_last;
    e.edges     = edges;
    sb.push_back(e);
  endtask

  // Hold start until the reader shows busy (bounded); start is ignored in DONE/ERR.
  task automatic launch(input logic [31:0] a, input bit s);
    start      = 1'b1;
    start_addr = a;
    is_signed  = s;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (busy) break;
    end
    start = 1'b0;
  endtask

  task automatic wait_result(output bit got, output bit obs_err, output bit both, output int edges);
    got = 1'b0; obs_err = 1'b0; both = 1'b0; edges = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done || error) begin
        got     = 1'b1;
        obs_err = error;
        both    = done && error;
        break;
      end
    end
  endtask

  task automatic load_rom();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h05;
    mem[8'h20] = 8'hE5; mem[8'h21] = 8'h8E; mem[8'h22] = 8'h26;
    mem[8'h30] = 8'h7F;
    mem[8'h40] = 8'hC0; mem[8'h41] = 8'hBB; mem[8'h42] = 8'h78;
    for (int i = 0; i < 4; i++) begin
      mem[8'h50 + i] = 8'hFF;
      mem[8'h60 + i] = 8'hFF;
      mem[8'h70 + i] = 8'h80;
      mem[8'h80 + i] = 8'h80;
      mem[8'h90 + i] = 8'h80;
    end
    mem[8'h54] = 8'h0F;
    mem[8'h64] = 8'h1F;
    mem[8'h74] = 8'h80;
    mem[8'h84] = 8'h78;
    mem[8'h94] = 8'h08;
    mem[8'hA0] = 8'h7F;
    mem[8'hA8] = 8'h3F;
    mem[8'hFF] = 8'h81;
    mem[8'h00] = 8'h01;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_addr = '0; is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, error, rom_bus.rom_read_en} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: busy/done/error/read_en=%b, required 0000",
               {busy, done, error, rom_bus.rom_read_en});
    end
    tests_run++;
    if (value !== 32'h0 || length !== 3'd0 || next_addr !== 32'h0 || rom_bus.rom_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_regs: value=%h length=%0d next=%h rom_addr=%h, required all 0",
               value, length, next_addr, rom_bus.rom_addr);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_vectors();
    vec_t vecs[$];
    exp_t e;
    bit got, obs_err, both;
    int edges;
    vecs.push_back('{32'h0000_0010, 1'b0, 1'b0, 32'h0000_0005, 1});
    vecs.push_back('{32'h0000_0020, 1'b0, 1'b0, 32'h0009_8765, 3});
    vecs.push_back('{32'h0000_0030, 1'b1, 1'b0, 32'hFFFF_FFFF, 1});
    vecs.push_back('{32'h0000_0040, 1'b1, 1'b0, 32'hFFFE_1DC0, 3});
    vecs.push_back('{32'h0000_00A0, 1'b0, 1'b0, 32'h0000_007F, 1});
    vecs.push_back('{32'h0000_00A8, 1'b1, 1'b0, 32'h0000_003F, 1});
    vecs.push_back('{32'h0000_0050, 1'b0, 1'b0, 32'hFFFF_FFFF, 5});
    vecs.push_back('{32'h0000_0060, 1'b0, 1'b1, 32'h0,        5});
    vecs.push_back('{32'h0000_0070, 1'b0, 1'b1, 32'h0,        5});
    vecs.push_back('{32'h0000_0080, 1'b1, 1'b0, 32'h8000_0000, 5});
    vecs.push_back('{32'h0000_0090, 1'b1, 1'b1, 32'h0,        5});
    vecs.push_back('{32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0081, 2});
    foreach (vecs[i]) begin
      if (vecs[i].is_err) push_err(vecs[i].addr + 32'(vecs[i].nbytes - 1), 2 * vecs[i].nbytes);
      else                push_done(vecs[i].addr, vecs[i].value, vecs[i].nbytes);
      launch(vecs[i].addr, vecs[i].sgn);
      wait_result(got, obs_err, both, edges);
      e = sb.pop_front();
      tests_run++;
      if (!got) begin
        tests_failed++;
        $display("FAIL vec%0d_result: no done/error within %0d cycles, required a pulse", i, edges);
      end else begin
        tests_run++;
        if (obs_err !== e.is_err || both) begin
          tests_failed++;
          $display("FAIL vec%0d_kind: error=%b done=%b, required error=%b", i, error, done, e.is_err);
        end
        tests_run++;
        if (edges != e.edges) begin
          tests_failed++;
          $display("FAIL vec%0d_latency: %0d cycles after start, required %0d", i, edges, e.edges);
        end
        tests_run++;
        if (value !== e.value || length !== e.length || next_addr !== e.next_addr) begin
          tests_failed++;
          $display("FAIL vec%0d_outputs: value=%h length=%0d next=%h, required %h %0d %h",
                   i, value, length, next_addr, e.value, e.length, e.next_addr);
        end
        tests_run++;
        if (busy !== 1'b0 || rom_bus.rom_read_en !== 1'b0 || rom_bus.rom_addr !== e.rom_last) begin
          tests_failed++;
          $display("FAIL vec%0d_bus: busy=%b read_en=%b rom_addr=%h, required 0 0 %h",
                   i, busy, rom_bus.rom_read_en, rom_bus.rom_addr, e.rom_last);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    bit got, obs_err, both;
    int edges;
    rom_enable = 1'b0;
    push_err(32'h0000_00C0, TIMEOUT);
    launch(32'h0000_00C0, 1'b0);
    wait_result(got, obs_err, both, edges);
    e = sb.pop_front();
    tests_run++;
    if (!got || !obs_err || both || edges != e.edges) begin
      tests_failed++;
      $display("FAIL timeout: got=%b error=%b done=%b after %0d cycles, required error at %0d",
               got, error, done, edges, e.edges);
    end
    tests_run++;
    if (value !== e.value || length !== e.length || next_addr !== e.next_addr) begin
      tests_failed++;
      $display("FAIL timeout_hold: value=%h length=%0d next=%h, required %h %0d %h",
               value, length, next_addr, e.value, e.length, e.next_addr);
    end
    rom_enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit got, obs_err, both;
    int edges;
    int pulses;
    push_done(32'h0000_0020, 32'h0009_8765, 3);
    push_done(32'h0000_0040, 32'hFFFE_1DC0, 3);
    launch(32'h0000_0020, 1'b0);
    // A second start while busy must be ignored.
    @(posedge clk);
    #1;
    start = 1'b1; start_addr = 32'h0000_0010; is_signed = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_result(got, obs_err, both, edges);
      if (k == 0) edges += 2;
      e = sb.pop_front();
      tests_run++;
      if (!got || obs_err || both || edges != e.edges) begin
        tests_failed++;
        $display("FAIL b2b%0d_kind: got=%b error=%b done=%b cycles=%0d, required done at %0d",
                 k, got, error, done, edges, e.edges);
      end
      tests_run++;
      if (value !== e.value || length !== e.length || next_addr !== e.next_addr) begin
        tests_failed++;
        $display("FAIL b2b%0d_outputs: value=%h length=%0d next=%h, required %h %0d %h",
                 k, value, length, next_addr, e.value, e.length, e.next_addr);
      end
      if (k == 0) launch(32'h0000_0040, 1'b1);
    end
    pulses = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (busy || done || error) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL b2b_idle: %0d active cycles after last decode, required 0", pulses);
    end
  endtask

  task automatic test_stray_ready();
    int active;
    stray_req = 1'b1;
    @(posedge clk);
    #1;
    stray_req = 1'b0;
    active = 0;
    repeat (4) begin
      if (busy || done || error) active++;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (active != 0 || value !== held_value || length !== held_len || next_addr !== held_next) begin
      tests_failed++;
      $display("FAIL stray_ready: active=%0d value=%h length=%0d next=%h, required 0 %h %0d %h",
               active, value, length, next_addr, held_value, held_len, held_next);
    end
  endtask

  task automatic test_reset_mid_fetch();
    exp_t e;
    bit got, obs_err, both;
    int edges;
    int pulses;
    launch(32'h0000_0020, 1'b0);
    // Two more edges: first byte consumed, second byte's ready now arriving.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, error, rom_bus.rom_read_en} !== 4'b0000 || value !== 32'h0 ||
        length !== 3'd0 || next_addr !== 32'h0 || rom_bus.rom_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_reset: flags=%b value=%h length=%0d next=%h rom_addr=%h, required all 0",
               {busy, done, error, rom_bus.rom_read_en}, value, length, next_addr, rom_bus.rom_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    held_value = '0; held_len = '0; held_next = '0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (busy || done || error) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL mid_reset_quiet: %0d active cycles after reset, required 0", pulses);
    end
    push_done(32'h0000_0020, 32'h0009_8765, 3);
    launch(32'h0000_0020, 1'b0);
    wait_result(got, obs_err, both, edges);
    e = sb.pop_front();
    tests_run++;
    if (!got || obs_err || both || edges != e.edges || value !== e.value ||
        length !== e.length || next_addr !== e.next_addr) begin
      tests_failed++;
      $display("FAIL mid_reset_fresh: got=%b err=%b cycles=%0d value=%h length=%0d next=%h, required done %0d %h %0d %h",
               got, obs_err, edges, value, length, next_addr, e.edges, e.value, e.length, e.next_addr);
    end
  endtask

  initial begin
    load_rom();
    test_reset();
    test_vectors();
    test_timeout();
    test_back_to_back();
    test_stray_ready();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
